rr_arb8: RTL and testbench
==========================

# rr_arb8

Round-robin arbiter that shares one 8:1 multiplexed resource between eight requesters. It drives the 3-bit select of the 8:1 mux and returns a one-hot grant to each requester. Grants are fair and bounded by a programmable hold limit. The block sits directly in front of the 8:1 mux: each requester asks for the shared path, and the arbiter steers `sel` to the winner.

## Interface
Parameters:
- `MAX_HOLD`, default 4: maximum consecutive cycles an owner keeps the grant while another requester is waiting. Legal range is 1..15.
- `HOLD_W`, default 4: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  8  request vector; bit i is requester i, level-sensitive.
- `gnt`  out  8  one-hot grant, or all-zero when idle. Registered.
- `sel`  out  3  binary index of the current owner, wired to the mux select. Registered.
- `busy`  out  1  high while a grant is active. Registered.

## Operation
- Two states:
  - IDLE: no owner.
  - OWNED: one owner, index held in `sel`.
- Internal state:
  - `ptr` (3 bits): highest-priority candidate.
  - `cnt` (HOLD_W bits): cycles held by the current owner.
- Pick rule: starting at `ptr`, scan upward with wrap (ptr, ptr+1, …, 7, 0, …, ptr-1). The first set `req` bit wins.
- Every new grant sets `ptr` to (winner+1) mod 8, using 3-bit natural wrap, and loads `cnt` to 1.
- IDLE:
  - If `req` is nonzero, grant the pick and go to OWNED.
  - Otherwise stay in IDLE.
- OWNED, release (`req[sel]`=0):
  - If any other `req` is set, hand off to the pick (computed from the updated `ptr`) with no idle cycle.
  - Otherwise go to IDLE with `gnt`=0 and `busy`=0.
- OWNED, preempt (`req[sel]`=1, `cnt`==MAX_HOLD, another `req` set): grant the pick, which excludes the owner because `ptr` already points past it.
- OWNED, continue (`req[sel]`=1 and no preempt condition):
  - Keep the grant.
  - `cnt` increments and saturates at MAX_HOLD.
  - With no contention the owner keeps the grant indefinitely.
- `sel` keeps its last value in IDLE. It is meaningful only when `busy`=1.
- `gnt` is always either zero or one-hot, and always equals (1<<sel) when `busy`=1.

## Timing
- Reset values, applied on the first `clk` edge with `rst_n`=0:
  - `gnt`=8'h00, `sel`=3'd0, `busy`=0
  - `ptr`=0, `cnt`=0, state IDLE
- Reset has priority over every other event. Asserting reset mid-grant drops the grant at that edge.
- Latency:
  - `req` asserted in IDLE → `gnt`/`sel`/`busy` valid after 1 edge.
  - Release or preempt → new owner's `gnt` on the next edge.
  - There is never a cycle with two grants, and no bubble cycle during a handoff.
- When an owner drops `req` and another bit rises in the same cycle, the new bit is eligible for the handoff pick.
- With MAX_HOLD=1 under full contention, the grant rotates every cycle.
- Requesters must hold `req` until granted. Dropping `req` before the grant simply removes the request; nothing is queued.

## Structure
- Shared include header holds:
  - `N_REQ`=8 and `SEL_W`=3
  - state encodings `ST_IDLE`=1'b0 and `ST_OWNED`=1'b1
- One combinational sub-module, `rr_pick8`:
  - inputs: `req`[7:0], `start`[2:0]
  - outputs: `idx`[2:0], `found`
  - implementation: rotate `req` right by `start`, priority-encode the lowest set bit, add `start` back mod 8.
- The top level contains only the state register, `ptr`, `cnt`, and the output registers.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `req`=8'hFF → `gnt`=8'h00, `sel`=0, `busy`=0 throughout; first grant after release is `gnt`=8'h01.
- Single requester: `req`=8'h04 → next edge `gnt`=8'h04, `sel`=2, `busy`=1. Clear `req` → next edge `gnt`=8'h00, `busy`=0, `sel` still 2.
- Full contention, MAX_HOLD=4, `req`=8'hFF held for 36 cycles → owners 0,1,…,7,0 in order, each held exactly 4 cycles, wrapping 7→0.
- Zero-bubble handoff: owner 3 holding, `req`=8'h2A, then `req[3]` dropped (`req`=8'h22) → next edge `gnt`=8'h20, `sel`=5, `busy` stays 1.
- No contention saturation: only `req`=8'h40 for 10 cycles → `gnt`=8'h40 all 10 cycles with no preemption. Then `req`=8'h41 → after 1 cycle (`cnt` already at MAX_HOLD) `gnt`=8'h01.
- Reset mid-grant: owner 4 active with `ptr`=5, assert `rst_n`=0 for 1 cycle → `gnt`=8'h00 at that edge. Release with `req`=8'hFF → `gnt`=8'h01 (`ptr` restarted at 0).

Source files
------------

// File: rtl/rr_arb8_pkg.sv
// Shared definitions for the rr_arb8 round-robin arbiter: requester count,
// select width, FSM state encoding and a small index-to-one-hot helper.
package rr_arb8_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    // Arbiter ownership state. The encodings are fixed so that the state bit
    // can be read directly in waveforms as "somebody owns the mux".
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // Convert a binary requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage : rr_arb8_pkg

// File: rtl/rr_arb8_if.sv
// Requester-side bus of the rr_arb8 arbiter. The slave modport is the arbiter
// view, the master modport is the requester/mux view.
interface rr_arb8_if;
    import rr_arb8_pkg::*;

    logic [N_REQ-1:0] req;   // level-sensitive request, bit i = requester i
    logic [N_REQ-1:0] gnt;   // one-hot grant, zero when idle
    logic [SEL_W-1:0] sel;   // mux select, meaningful only while busy
    logic             busy;  // a grant is active

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy
    );

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy
    );

endinterface : rr_arb8_if

// File: rtl/rr_arb8_pick8.sv
// Combinational round-robin pick: the first set request bit found when
// scanning upward from start, wrapping 7 -> 0.
module rr_pick8
    import rr_arb8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]   offset;

    // Rotating right by start puts the highest-priority candidate at bit 0,
    // so a plain lowest-set-bit encoder yields the distance from start.
    assign req_dbl = {req, req} >> start;
    assign req_rot = req_dbl[N_REQ-1:0];

    // Priority-encode the lowest set bit of the rotated request vector.
    always_comb begin
        // NOTE: offset gets a default before the loop so no path leaves it unassigned (no latch).
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    // Adding start back uses the natural 3-bit wrap to return to absolute index.
    assign idx   = start + offset;
    assign found = |req;

endmodule : rr_pick8

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter in front of an 8:1 mux. Holds state, the
// rotating priority pointer, the hold counter and the registered outputs;
// the scan itself lives in rr_pick8.
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_arb8_if.slave    bus
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [HOLD_W-1:0] cnt;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             owner_req;
    logic             others_req;
    logic             hold_expired;
    logic             take_grant;

    // The pointer already sits one past the current owner, so the same pick
    // serves the idle grant, the release handoff and the preempt: in the
    // preempt case the owner is the last candidate scanned and only wins
    // when nobody else is asking.
    rr_pick8 u_pick (
        .req   (bus.req),
        .start (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Decode the arbitration event for this cycle from state and requests.
    always_comb begin
        owner_req    = bus.req[bus.sel];
        others_req   = |(bus.req & ~sel_to_onehot(bus.sel));
        hold_expired = (cnt == HOLD_MAX);
        take_grant   = 1'b0;
        unique case (state)
            ST_IDLE:  take_grant = pick_found;
            ST_OWNED: take_grant = owner_req ? (hold_expired && others_req) : pick_found;
            default:  take_grant = 1'b0;
        endcase
    end

    // Ownership FSM with pointer, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: every register in this block uses <= so all of them see the pre-edge values.
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            bus.gnt  <= '0;
            bus.sel  <= '0;
            bus.busy <= 1'b0;
        end else if (take_grant) begin
            // Any new grant: steer the mux, move priority past the winner,
            // restart the hold count.
            state    <= ST_OWNED;
            ptr      <= pick_idx + SEL_W'(1);
            cnt      <= HOLD_ONE;
            bus.gnt  <= sel_to_onehot(pick_idx);
            bus.sel  <= pick_idx;
            bus.busy <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // Nothing requested: sel keeps its last value.
                    state <= ST_IDLE;
                end
                ST_OWNED: begin
                    if (!owner_req) begin
                        // Owner released and nobody else is waiting.
                        state    <= ST_IDLE;
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                    end else if (!hold_expired) begin
                        // Owner continues; count saturates at the hold limit
                        // so an uncontended owner can hold indefinitely.
                        cnt <= cnt + HOLD_ONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule : rr_arb8

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8 with the default MAX_HOLD=4.
module tb_rr_arb8;
    import rr_arb8_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_arb8_if bus ();

    rr_arb8 #(
        .MAX_HOLD (4),
        .HOLD_W   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (bus.gnt !== 8'h00 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got gnt=%h sel=%0d busy=%b want gnt=00 sel=0 busy=0",
                         c, bus.gnt, bus.sel, bus.busy);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant got gnt=%h sel=%0d busy=%b want gnt=01 sel=0 busy=1",
                     bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req = 8'h04;
        tick();
        checks++;
        if (bus.gnt !== 8'h04 || bus.sel !== 3'd2 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got gnt=%h sel=%0d busy=%b want gnt=04 sel=2 busy=1",
                     bus.gnt, bus.sel, bus.busy);
        end
        bus.req = 8'h00;
        tick();
        checks++;
        if (bus.gnt !== 8'h00 || bus.sel !== 3'd2 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release got gnt=%h sel=%0d busy=%b want gnt=00 sel=2 busy=0",
                     bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_full_contention();
        logic [2:0] exp_sel;
        logic [7:0] exp_gnt;
        apply_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 36; k++) begin
            tick();
            exp_sel = 3'((k / 4) % 8);
            exp_gnt = 8'h01 << exp_sel;
            checks++;
            if (bus.gnt !== exp_gnt || bus.sel !== exp_sel || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL contention cyc=%0d got gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=1",
                         k, bus.gnt, bus.sel, bus.busy, exp_gnt, exp_sel);
            end
        end
    endtask

    task automatic test_handoff();
        apply_reset();
        bus.req = 8'h08;
        tick();
        checks++;
        if (bus.gnt !== 8'h08 || bus.sel !== 3'd3) begin
            failures++;
            $display("FAIL handoff_setup got gnt=%h sel=%0d want gnt=08 sel=3", bus.gnt, bus.sel);
        end
        bus.req = 8'h2A;
        tick();
        checks++;
        if (bus.gnt !== 8'h08 || bus.sel !== 3'd3 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL handoff_keep got gnt=%h sel=%0d busy=%b want gnt=08 sel=3 busy=1",
                     bus.gnt, bus.sel, bus.busy);
        end
        bus.req = 8'h22;
        tick();
        checks++;
        if (bus.gnt !== 8'h20 || bus.sel !== 3'd5 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL handoff_next got gnt=%h sel=%0d busy=%b want gnt=20 sel=5 busy=1",
                     bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_same_cycle_rise();
        // Owner 3 drops while bit 0 rises: scan from 4 wraps to requester 0.
        apply_reset();
        bus.req = 8'h08;
        tick();
        bus.req = 8'h01;
        tick();
        checks++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rise_handoff got gnt=%h sel=%0d busy=%b want gnt=01 sel=0 busy=1",
                     bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.req = 8'h40;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (bus.gnt !== 8'h40 || bus.sel !== 3'd6 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL saturate cyc=%0d got gnt=%h sel=%0d busy=%b want gnt=40 sel=6 busy=1",
                         k, bus.gnt, bus.sel, bus.busy);
            end
        end
        bus.req = 8'h41;
        tick();
        checks++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL saturate_preempt got gnt=%h sel=%0d busy=%b want gnt=01 sel=0 busy=1",
                     bus.gnt, bus.sel, bus.busy);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        bus.req = 8'h10;
        tick();
        checks++;
        if (bus.gnt !== 8'h10 || bus.sel !== 3'd4) begin
            failures++;
            $display("FAIL midrst_setup got gnt=%h sel=%0d want gnt=10 sel=4", bus.gnt, bus.sel);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 8'h00 || bus.busy !== 1'b0 || bus.sel !== 3'd0) begin
            failures++;
            $display("FAIL midrst_drop got gnt=%h sel=%0d busy=%b want gnt=00 sel=0 busy=0",
                     bus.gnt, bus.sel, bus.busy);
        end
        rst_n   = 1'b1;
        bus.req = 8'hFF;
        tick();
        checks++;
        if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_restart got gnt=%h sel=%0d busy=%b want gnt=01 sel=0 busy=1",
                     bus.gnt, bus.sel, bus.busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        test_reset();
        test_single();
        test_full_contention();
        test_handoff();
        test_same_cycle_rise();
        test_saturation();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_arb8
